// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result handshake bundle for the pipelined ripple adder.
// master = operand source and result sink; slave = the adder itself.
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, in1, in2, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, in1, in2, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract split into STAGES ripple slices, one slice per pipeline stage,
// with a valid/ready handshake and a global stall. WIDTH must be a multiple of STAGES.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_ripple_adder_if.slave bus
);
  localparam int SLICE = WIDTH / STAGES;

  logic adv;
  logic out_valid_int;

  // Whole pipe moves together: a held result freezes every stage, bubbles included.
  assign adv          = ~out_valid_int | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO   = k * SLICE;
    localparam int DONE = LO + SLICE;

    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic                c_in_k;
    logic                v_in;
    logic [SLICE:0]      cy;
    logic [SLICE-1:0]    p;
    logic [DONE-1:0]     s_nxt;
    logic [DONE-1:0]     s_r;
    logic                c_r;
    logic                v_r;

    if (k == 0) begin : g_first
      assign a_in   = bus.in1;
      assign b_in   = bus.sub ? ~bus.in2 : bus.in2;
      assign c_in_k = bus.c_in;
      assign v_in   = bus.in_valid;
      assign s_nxt  = p;
    end else begin : g_next
      assign a_in   = stg[k-1].g_ops.a_r;
      assign b_in   = stg[k-1].g_ops.b_r;
      assign c_in_k = stg[k-1].c_r;
      assign v_in   = stg[k-1].v_r;
      assign s_nxt  = {p, stg[k-1].s_r};
    end

    always_comb begin
      cy    = '0;
      cy[0] = c_in_k;
      for (int i = 0; i < SLICE; i++) begin
        cy[i+1] = (a_in[i] & b_in[i]) | (cy[i] & (a_in[i] ^ b_in[i]));
      end
      p = a_in[SLICE-1:0] ^ b_in[SLICE-1:0] ^ cy[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        s_r <= '0;
        c_r <= 1'b0;
      end else if (adv) begin
        v_r <= v_in;
        s_r <= s_nxt;
        c_r <= cy[SLICE];
      end
    end

    if (k < STAGES - 1) begin : g_ops
      // Only the slices not yet added travel forward.
      localparam int REM = WIDTH - DONE;
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv) begin
          a_r <= a_in[WIDTH-LO-1:SLICE];
          b_r <= b_in[WIDTH-LO-1:SLICE];
        end
      end
    end else begin : g_last
      logic ovf_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (adv) begin
          ovf_r <= cy[SLICE] ^ cy[SLICE-1];
        end
      end
    end
  end

  assign out_valid_int = stg[STAGES-1].v_r;
  assign bus.out_valid = out_valid_int;
  assign bus.sum       = out_valid_int ? stg[STAGES-1].s_r : '0;
  assign bus.c_out     = out_valid_int & stg[STAGES-1].c_r;
  assign bus.overflow  = out_valid_int & stg[STAGES-1].g_last.ovf_r;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: directed scenarios on the 32/4 build and
// a randomized regression across four parameter sets against an arithmetic reference model.
module tb_pipelined_ripple_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipelined_ripple_adder_if #(.WIDTH(32)) bus32  ();
  pipelined_ripple_adder_if #(.WIDTH(8))  bus8s8 ();
  pipelined_ripple_adder_if #(.WIDTH(8))  bus8s1 ();
  pipelined_ripple_adder_if #(.WIDTH(64)) bus64  ();

  pipelined_ripple_adder #(.WIDTH(32), .STAGES(4)) u_w32s4 (.clk(clk), .rst(rst), .bus(bus32));
  pipelined_ripple_adder #(.WIDTH(8),  .STAGES(8)) u_w8s8  (.clk(clk), .rst(rst), .bus(bus8s8));
  pipelined_ripple_adder #(.WIDTH(8),  .STAGES(1)) u_w8s1  (.clk(clk), .rst(rst), .bus(bus8s1));
  pipelined_ripple_adder #(.WIDTH(64), .STAGES(2)) u_w64s2 (.clk(clk), .rst(rst), .bus(bus64));

  // Returns {overflow, c_out, sum zero-extended to 64} for a w-bit add/subtract.
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic ci, input logic sb);
    logic [64:0] mask, aa, bb, full;
    logic [63:0] s;
    logic        co, ov;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = (sb ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = aa + bb + {64'd0, ci};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s};
  endfunction

  task automatic drive32(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb);
    bus32.in_valid = iv;
    bus32.in1      = a;
    bus32.in2      = b;
    bus32.c_in     = ci;
    bus32.sub      = sb;
  endtask

  task automatic idle_all();
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus32.out_ready  = 1'b1;
    bus8s8.in_valid  = 1'b0; bus8s8.in1 = '0; bus8s8.in2 = '0; bus8s8.c_in = 1'b0; bus8s8.sub = 1'b0;
    bus8s8.out_ready = 1'b1;
    bus8s1.in_valid  = 1'b0; bus8s1.in1 = '0; bus8s1.in2 = '0; bus8s1.c_in = 1'b0; bus8s1.sub = 1'b0;
    bus8s1.out_ready = 1'b1;
    bus64.in_valid   = 1'b0; bus64.in1  = '0; bus64.in2  = '0; bus64.c_in  = 1'b0; bus64.sub  = 1'b0;
    bus64.out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", bus32.out_valid); end
    n_cmp++; if (bus32.sum !== 32'd0) begin n_fail++; $display("FAIL reset_sum got %h expected 0", bus32.sum); end
    n_cmp++; if (bus32.c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out got %b expected 0", bus32.c_out); end
    n_cmp++; if (bus32.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b expected 0", bus32.overflow); end
    n_cmp++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", bus32.in_ready); end
    n_cmp++;
    if ({bus8s8.out_valid, bus8s1.out_valid, bus64.out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_other_valid got %b expected 000", {bus8s8.out_valid, bus8s1.out_valid, bus64.out_valid});
    end
  endtask

  task automatic test_carry_chain();
    @(posedge clk); #1;
    drive32(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL carry_accept in_ready got %b expected 1", bus32.in_ready); end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (bus32.out_valid !== (c == 4)) begin
        n_fail++; $display("FAIL carry_latency cycle %0d out_valid got %b expected %b", c, bus32.out_valid, (c == 4));
      end
      if (c == 4) begin
        n_cmp++;
        if ({bus32.overflow, bus32.c_out, bus32.sum} !== {1'b0, 1'b1, 32'h0000_0000}) begin
          n_fail++; $display("FAIL carry_result ovf/cout/sum got %b/%b/%h expected 0/1/00000000", bus32.overflow, bus32.c_out, bus32.sum);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 0)      drive32(1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
      else if (c == 1) drive32(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      else             drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (c >= 1) begin
        n_cmp++;
        if (bus32.out_valid !== (c == 4 || c == 5)) begin
          n_fail++; $display("FAIL b2b_valid cycle %0d got %b expected %b", c, bus32.out_valid, (c == 4 || c == 5));
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({bus32.overflow, bus32.c_out, bus32.sum} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin
          n_fail++; $display("FAIL b2b_sub ovf/cout/sum got %b/%b/%h expected 0/0/fffffffe", bus32.overflow, bus32.c_out, bus32.sum);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({bus32.overflow, bus32.c_out, bus32.sum} !== {1'b1, 1'b0, 32'h8000_0000}) begin
          n_fail++; $display("FAIL b2b_ovf ovf/cout/sum got %b/%b/%h expected 1/0/80000000", bus32.overflow, bus32.c_out, bus32.sum);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [65:0] q[$];
    logic [65:0] act, exp, snap;
    logic [31:0] a, b;
    logic        ci, sb, stalling, was_stalling;
    int          sent, got, stall_left;
    sent = 0; got = 0; stall_left = 3; was_stalling = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(posedge clk); #1;
      stalling = bus32.out_valid && (stall_left > 0);
      if (stalling) stall_left--;
      bus32.out_ready = !stalling;
      a  = $urandom();
      b  = $urandom();
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      drive32(sent < 8, a, b, ci, sb);
      @(negedge clk);
      act = {bus32.overflow, bus32.c_out, 32'd0, bus32.sum};
      if (stalling) begin
        n_cmp++;
        if (bus32.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b expected 0", bus32.in_ready); end
        if (was_stalling) begin
          n_cmp++;
          if (act !== snap || bus32.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold got %h valid %b expected %h valid 1", act, bus32.out_valid, snap);
          end
        end
        snap = act;
      end
      was_stalling = stalling;
      if (bus32.out_valid && bus32.out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stall_result unexpected result %h expected none", act);
        end else begin
          exp = q.pop_front();
          if (act !== exp) begin n_fail++; $display("FAIL stall_result #%0d got %h expected %h", got, act, exp); end
        end
        got++;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        q.push_back(ref_model(32, {32'd0, a}, {32'd0, b}, ci, sb));
        sent++;
      end
    end
    n_cmp++; if (got != 8) begin n_fail++; $display("FAIL stall_count got %0d expected 8", got); end
    bus32.out_ready = 1'b1;
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_bubbles();
    logic [65:0] q[$];
    logic [65:0] act, exp;
    logic [31:0] a, b;
    logic        ci, sb, iv, ev;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      iv = (c < 4) && (c % 2 == 0);
      a  = $urandom();
      b  = $urandom();
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      drive32(iv, a, b, ci, sb);
      @(negedge clk);
      ev = (c >= 4) && (c <= 7) && ((c - 4) % 2 == 0);
      n_cmp++;
      if (bus32.out_valid !== ev) begin n_fail++; $display("FAIL bubble_valid cycle %0d got %b expected %b", c, bus32.out_valid, ev); end
      if (bus32.out_valid && q.size() != 0) begin
        act = {bus32.overflow, bus32.c_out, 32'd0, bus32.sum};
        exp = q.pop_front();
        n_cmp++;
        if (act !== exp) begin n_fail++; $display("FAIL bubble_result cycle %0d got %h expected %h", c, act, exp); end
      end
      if (bus32.in_valid && bus32.in_ready) q.push_back(ref_model(32, {32'd0, a}, {32'd0, b}, ci, sb));
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      rst = (c == 3);
      if (c < 3) drive32(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else       drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (c < 3) begin
        n_cmp++;
        if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept cycle %0d in_ready got %b expected 1", c, bus32.in_ready); end
      end else begin
        n_cmp++;
        if ({bus32.out_valid, bus32.overflow, bus32.c_out, bus32.sum} !== 35'd0) begin
          n_fail++; $display("FAIL rstmid_flush cycle %0d valid/ovf/cout/sum got %b/%b/%b/%h expected all 0",
                              c, bus32.out_valid, bus32.overflow, bus32.c_out, bus32.sum);
        end
        if (c > 3) begin
          n_cmp++;
          if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready cycle %0d got %b expected 1", c, bus32.in_ready); end
        end
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [65:0] q32[$], q8s8[$], q8s1[$], q64[$];
    logic [65:0] act, exp;
    logic [63:0] r1, r2;
    logic        ci, sb, iv, ordy, draining;
    int          acc32, acc8s8, acc8s1, acc64;
    acc32 = 0; acc8s8 = 0; acc8s1 = 0; acc64 = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      draining = (acc32 >= 1000) && (acc8s8 >= 1000) && (acc8s1 >= 1000) && (acc64 >= 1000);
      if (draining && q32.size() == 0 && q8s8.size() == 0 && q8s1.size() == 0 && q64.size() == 0) break;
      @(posedge clk); #1;
      r1   = {$urandom(), $urandom()};
      r2   = {$urandom(), $urandom()};
      ci   = 1'($urandom_range(0, 1));
      sb   = 1'($urandom_range(0, 1));
      iv   = !draining && ($urandom_range(0, 3) != 0);
      ordy = draining || ($urandom_range(0, 3) != 0);
      drive32(iv, r1[31:0], r2[31:0], ci, sb);
      bus32.out_ready = ordy;
      bus8s8.in_valid = iv; bus8s8.in1 = r1[7:0]; bus8s8.in2 = r2[7:0]; bus8s8.c_in = ci; bus8s8.sub = sb;
      bus8s8.out_ready = ordy;
      bus8s1.in_valid = iv; bus8s1.in1 = r1[7:0]; bus8s1.in2 = r2[7:0]; bus8s1.c_in = ci; bus8s1.sub = sb;
      bus8s1.out_ready = ordy;
      bus64.in_valid = iv; bus64.in1 = r1; bus64.in2 = r2; bus64.c_in = ci; bus64.sub = sb;
      bus64.out_ready = ordy;
      @(negedge clk);

      act = {bus32.overflow, bus32.c_out, 32'd0, bus32.sum};
      n_cmp++;
      if (bus32.out_valid && bus32.out_ready) begin
        exp = (q32.size() != 0) ? q32.pop_front() : 66'bx;
        if (act !== exp) begin n_fail++; $display("FAIL sweep_w32s4 got %h expected %h", act, exp); end
      end else if (!bus32.out_valid && act !== 66'd0) begin
        n_fail++; $display("FAIL sweep_w32s4_gate got %h expected 0", act);
      end
      if (bus32.in_valid && bus32.in_ready) begin q32.push_back(ref_model(32, r1, r2, ci, sb)); acc32++; end

      act = {bus8s8.overflow, bus8s8.c_out, 56'd0, bus8s8.sum};
      n_cmp++;
      if (bus8s8.out_valid && bus8s8.out_ready) begin
        exp = (q8s8.size() != 0) ? q8s8.pop_front() : 66'bx;
        if (act !== exp) begin n_fail++; $display("FAIL sweep_w8s8 got %h expected %h", act, exp); end
      end else if (!bus8s8.out_valid && act !== 66'd0) begin
        n_fail++; $display("FAIL sweep_w8s8_gate got %h expected 0", act);
      end
      if (bus8s8.in_valid && bus8s8.in_ready) begin q8s8.push_back(ref_model(8, r1, r2, ci, sb)); acc8s8++; end

      act = {bus8s1.overflow, bus8s1.c_out, 56'd0, bus8s1.sum};
      n_cmp++;
      if (bus8s1.out_valid && bus8s1.out_ready) begin
        exp = (q8s1.size() != 0) ? q8s1.pop_front() : 66'bx;
        if (act !== exp) begin n_fail++; $display("FAIL sweep_w8s1 got %h expected %h", act, exp); end
      end else if (!bus8s1.out_valid && act !== 66'd0) begin
        n_fail++; $display("FAIL sweep_w8s1_gate got %h expected 0", act);
      end
      if (bus8s1.in_valid && bus8s1.in_ready) begin q8s1.push_back(ref_model(8, r1, r2, ci, sb)); acc8s1++; end

      act = {bus64.overflow, bus64.c_out, bus64.sum};
      n_cmp++;
      if (bus64.out_valid && bus64.out_ready) begin
        exp = (q64.size() != 0) ? q64.pop_front() : 66'bx;
        if (act !== exp) begin n_fail++; $display("FAIL sweep_w64s2 got %h expected %h", act, exp); end
      end else if (!bus64.out_valid && act !== 66'd0) begin
        n_fail++; $display("FAIL sweep_w64s2_gate got %h expected 0", act);
      end
      if (bus64.in_valid && bus64.in_ready) begin q64.push_back(ref_model(64, r1, r2, ci, sb)); acc64++; end
    end
    n_cmp++;
    if (acc32 < 1000 || acc8s8 < 1000 || acc8s1 < 1000 || acc64 < 1000 ||
        q32.size() != 0 || q8s8.size() != 0 || q8s1.size() != 0 || q64.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_timeout accepted %0d/%0d/%0d/%0d pending %0d/%0d/%0d/%0d expected >=1000 accepted and 0 pending",
               acc32, acc8s8, acc8s1, acc64, q32.size(), q8s8.size(), q8s1.size(), q64.size());
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_reset_mid();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
